bus_arbiter: RTL and testbench

Round-robin bus arbiter that consumes the random request pulses produced by the per-master LFSR request generators and grants bus ownership to one master at a time. It sits directly downstream of the request generators: one `rq` bit per master comes in, a one-hot registered grant plus owner index goes out to the bus mux. Ownership is held while the owner keeps requesting, is followed by a one-cycle turnaround, and rotates fairly among contending masters.

---
 rtl/bus_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 33 +++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_t;

    localparam int unsigned TURNAROUND_CYCLES = 1;
    localparam int unsigned HOLD_W            = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_picker #(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         rq,
    input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
    output logic                           any,
    output logic [$clog2(NUM_MASTERS)-1:0] win
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned XW = IW + 1;

    logic [XW-1:0] idx;

    // One extra index bit so ptr+i never overflows before the wrap compare.
    always_comb begin
        any = 1'b0;
        win = '0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = {1'b0, ptr} + XW'(i);
            if (idx >= XW'(NUM_MASTERS)) begin
                idx = idx - XW'(NUM_MASTERS);
            end
            if (!any && rq[idx[IW-1:0]]) begin
                any = 1'b1;
                win = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround between ownerships.
// Optional hold-time limit enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         rq,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           timeout
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || MAX_HOLD < 1 ||
        MAX_HOLD >= (1 << HOLD_W) || TURNAROUND_CYCLES != 1) begin : g_bad_cfg
        $error("bus_arbiter: illegal parameter configuration");
    end

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_adv;
    logic          any;
    logic [IW-1:0] win;

    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .rq  (rq),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    // Previous owner drops to lowest priority; explicit wrap for non-power-of-two counts.
    assign ptr_adv = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + IW'(1);

`ifdef BUS_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_RELEASE: begin
                    if (any) begin
                        state    <= ST_GRANT;
                        gnt      <= NUM_MASTERS'(1) << win;
                        busy     <= 1'b1;
                        owner    <= win;
                        hold_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!rq[owner] || (hold_cnt + HOLD_W'(1) >= HOLD_W'(MAX_HOLD))) begin
                        state   <= ST_RELEASE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= ptr_adv;
                        timeout <= rq[owner];
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RELEASE: begin
                    if (any) begin
                        state <= ST_GRANT;
                        gnt   <= NUM_MASTERS'(1) << win;
                        busy  <= 1'b1;
                        owner <= win;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!rq[owner]) begin
                        state <= ST_RELEASE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_adv;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rq  = 4'b0000;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ownership as a transaction, pick by modular scan.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .rq      (rq),
        .gnt     (gnt),
        .busy    (busy),
        .owner   (owner),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit found;
        int w;
        m_to = 0;
        if (m_busy) begin
            m_hold++;
            if (!r[m_owner] || (TO_EN && m_hold >= MAX_HOLD)) begin
                m_to   = r[m_owner];
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else begin
            found = 0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found = 1;
                    w     = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_owner = w;
                m_hold  = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt();
        return m_busy ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    // Drive rq at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic cyc(input logic [3:0] v);
        @(negedge clk);
        rq = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rq  = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b busy=%b owner=%0d timeout=%b, want 0000/0/0/0", gnt, busy, owner, timeout);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        cyc(4'b0001);
        n_checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b busy=%b, want 0001/1", gnt, busy);
        end
        repeat (4) cyc(4'b0001);
        cyc(4'b0000);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        cyc(4'b0011);
        n_checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL single_ptr_advanced: gnt=%b owner=%0d, want 0010/1", gnt, owner);
        end
        cyc(4'b0000);
    endtask

    task automatic test_contention();
        do_reset();
        cyc(4'b0110);
        n_checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL contention_first: gnt=%b owner=%0d, want 0010/1", gnt, owner);
        end
        cyc(4'b0110);
        cyc(4'b0100);
        n_checks++;
        if (gnt !== 4'b0000 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL contention_turnaround: gnt=%b owner=%0d, want 0000/1", gnt, owner);
        end
        cyc(4'b0100);
        n_checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL contention_second: gnt=%b owner=%0d, want 0100/2", gnt, owner);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] oh;
        logic [3:0] drop;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            oh   = 4'b0001 << (k % 4);
            drop = 4'b1111 & ~oh;
            cyc(4'b1111);
            n_checks++;
            if (gnt !== oh) begin
                n_fail++;
                $display("FAIL fairness_grant_%0d: gnt=%b, want %b", k, gnt, oh);
            end
            cyc(4'b1111);
            cyc(drop);
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL fairness_gap_%0d: gnt=%b, want 0000", k, gnt);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 0; k < MAX_HOLD; k++) begin
            cyc(4'b0011);
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold_%0d: gnt=%b timeout=%b, want 0001/0", k, gnt, timeout);
            end
        end
        cyc(4'b0011);
        n_checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: gnt=%b timeout=%b, want 0000/1", gnt, timeout);
        end
        cyc(4'b0011);
        n_checks++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next_owner: gnt=%b timeout=%b, want 0010/0", gnt, timeout);
        end
`else
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0011);
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL unbounded_hold_%0d: gnt=%b timeout=%b, want 0001/0", k, gnt, timeout);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cyc(4'b0100);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL midreset_setup: gnt=%b, want 0100", gnt);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_async: gnt=%b busy=%b owner=%0d, want 0000/0/0", gnt, busy, owner);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_step(rq);
        #1;
        n_checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset_regrant: gnt=%b owner=%0d, want 0100/2", gnt, owner);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] eg;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            cyc(r);
            eg = exp_gnt();
            n_checks++;
            if (gnt !== eg) begin
                n_fail++;
                $display("FAIL rand_gnt cycle %0d rq=%b: gnt=%b, want %b", c, r, gnt, eg);
            end
            n_checks++;
            if (busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand_busy cycle %0d: busy=%b, want %b", c, busy, m_busy);
            end
            n_checks++;
            if (owner !== 2'(m_owner)) begin
                n_fail++;
                $display("FAIL rand_owner cycle %0d: owner=%0d, want %0d", c, owner, m_owner);
            end
            n_checks++;
            if (timeout !== m_to) begin
                n_fail++;
                $display("FAIL rand_timeout cycle %0d: timeout=%b, want %b", c, timeout, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
